// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, requester owner ids and fixed field widths.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Requester identities, also used as the last-grant encoding.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int MASK_W = 4;

    // Wide enough for the largest legal command latency (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and memory command signals
// shared between the arbiter and its surroundings.
//   slave  modport : arbiter view (requests/mem rdata in, acks/commands out)
//   master modport : environment view (core requesters and memory model)
// Parameters: XLEN data width, ADDR_W byte-address width.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // Fetch requester
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_ack;
    logic [XLEN-1:0]   o_if_rdata;
    // Data requester
    logic              i_d_ren;
    logic              i_d_wen;
    logic [ADDR_W-1:0] i_d_addr;
    logic [XLEN-1:0]   i_d_wdata;
    logic [MASK_W-1:0] i_d_mask;
    logic              o_d_ack;
    logic [XLEN-1:0]   o_d_rdata;
    // Memory command port
    logic              o_mem_ren;
    logic              o_mem_wen;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [XLEN-1:0]   o_mem_wdata;
    logic [MASK_W-1:0] o_mem_mask;
    logic [XLEN-1:0]   i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_d_ren, i_d_wen, i_d_addr, i_d_wdata,
               i_d_mask, i_mem_rdata,
        output o_if_ack, o_if_rdata, o_d_ack, o_d_rdata, o_mem_ren,
               o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
    );

    modport master (
        output i_if_req, i_if_addr, i_d_ren, i_d_wen, i_d_addr, i_d_wdata,
               i_d_mask, i_mem_rdata,
        input  o_if_ack, o_if_rdata, o_d_ack, o_d_rdata, o_mem_ren,
               o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
    );

endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and data requesters.
//   if_req_i     : fetch request pending
//   d_req_i      : data (load or store) request pending
//   last_grant_i : owner of the previous grant (used only in fair mode)
//   winner_o     : OWN_IF or OWN_D
// Macro MEM_ARB_FAIR_EN: when defined, contention goes to the requester that
// did not win last time; otherwise data always beats fetch.
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic last_grant_i,
    output logic winner_o
);

`ifndef MEM_ARB_FAIR_EN
    // Fixed priority ignores history; keep the port without a dangling load.
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant_i;
`endif

    // Winner selection; a lone requester always wins.
    always_comb begin
        winner_o = OWN_IF;
        if (d_req_i && if_req_i) begin
`ifdef MEM_ARB_FAIR_EN
            if (last_grant_i == OWN_D) begin
                winner_o = OWN_IF;
            end else begin
                winner_o = OWN_D;
            end
`else
            winner_o = OWN_D;
`endif
        end else if (d_req_i) begin
            winner_o = OWN_D;
        end else begin
            winner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and data
// load/store. A level-held request is granted in IDLE, turned into one
// memory command held for MEM_LATENCY cycles, then acknowledged with a
// one-cycle ack carrying the registered read data.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (aborts any command in flight)
//   bus     : mem_port_arbiter_if.slave (requesters + memory command port)
// Parameters: XLEN, ADDR_W, MEM_LATENCY (1..15).
// Macro MEM_ARB_FAIR_EN enables alternating grants under contention.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input logic               i_clk,
    input logic               i_rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_q;
    logic              mem_ren_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [MASK_W-1:0] mem_mask_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [XLEN-1:0]   if_rdata_q;
    logic [XLEN-1:0]   d_rdata_q;

    logic d_req_s;
    logic winner_s;
    logic last_grant_s;

    assign d_req_s = bus.i_d_ren | bus.i_d_wen;

`ifdef MEM_ARB_FAIR_EN
    logic last_grant_q;
    assign last_grant_s = last_grant_q;
`else
    assign last_grant_s = OWN_IF;
`endif

    mem_arb_pick u_pick (
        .if_req_i     (bus.i_if_req),
        .d_req_i      (d_req_s),
        .last_grant_i (last_grant_s),
        .winner_o     (winner_s)
    );

    // Arbiter FSM: grant, command hold/countdown, ack pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_FAIR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_if_req || d_req_s) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= LAT_C;
                        owner_q <= winner_s;
`ifdef MEM_ARB_FAIR_EN
                        last_grant_q <= winner_s;
`endif
                        if (winner_s == OWN_D) begin
                            // Store wins when both ren and wen are high.
                            mem_ren_q   <= ~bus.i_d_wen;
                            mem_wen_q   <= bus.i_d_wen;
                            mem_addr_q  <= bus.i_d_addr;
                            mem_wdata_q <= bus.i_d_wdata;
                            mem_mask_q  <= bus.i_d_mask;
                        end else begin
                            mem_ren_q   <= 1'b1;
                            mem_wen_q   <= 1'b0;
                            mem_addr_q  <= bus.i_if_addr;
                            mem_wdata_q <= '0;
                            mem_mask_q  <= '0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // Last command cycle: memory data is valid now.
                        state_q     <= ST_ACK;
                        mem_ren_q   <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_mask_q  <= '0;
                        if (owner_q == OWN_D) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= mem_ren_q ? bus.i_mem_rdata : '0;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.i_mem_rdata;
                        end
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_ACK: begin
                    state_q    <= ST_IDLE;
                    if_ack_q   <= 1'b0;
                    d_ack_q    <= 1'b0;
                    if_rdata_q <= '0;
                    d_rdata_q  <= '0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    mem_ren_q   <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_mask_q  <= '0;
                    if_ack_q    <= 1'b0;
                    d_ack_q     <= 1'b0;
                    if_rdata_q  <= '0;
                    d_rdata_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_mem_ren   = mem_ren_q;
    assign bus.o_mem_wen   = mem_wen_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_mask  = mem_mask_q;
    assign bus.o_if_ack    = if_ack_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_d_ack     = d_ack_q;
    assign bus.o_d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed and randomized stimulus for mem_port_arbiter, checked every cycle
// against a transaction-level reference: a grant at cycle t drives the
// command on cycles t+1..t+L and the ack on cycle t+L+1, the arbiter is free
// again at t+L+2, and read data is whatever memory showed on cycle t+L.
// Honours MEM_ARB_FAIR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int L = 2;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    mem_port_arbiter_if #(.XLEN(32), .ADDR_W(32)) bus ();

    mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LATENCY(L)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference transaction record
    bit          in_reset;
    bit          txn_valid;
    int          t_start;
    bit          t_d, t_write;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [3:0]  t_mask;
    int          free_at;
    bit          last_d;

    // Stimulus controls and observed ack bookkeeping
    bit if_reissue, d_reissue, rand_mode, rand_rd;
    bit e_if_ack, e_d_ack;
    int if_ack_n = 0, d_ack_n = 0, if_ack_cyc = 0, d_ack_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Decide a grant from the inputs held in the current cycle.
    task automatic model_sample();
        bit dreq, use_d;
        if (!in_reset) begin
            if (txn_valid && cyc == t_start + L) t_rdata = bus.i_mem_rdata;
            dreq = bus.i_d_ren | bus.i_d_wen;
            if (cyc >= free_at && (dreq || bus.i_if_req)) begin
                if (dreq && bus.i_if_req) use_d = FAIR ? !last_d : 1'b1;
                else use_d = dreq;
                txn_valid = 1'b1;
                t_start   = cyc;
                t_d       = use_d;
                t_write   = use_d && bus.i_d_wen;
                t_addr    = use_d ? bus.i_d_addr : bus.i_if_addr;
                t_wdata   = bus.i_d_wdata;
                t_mask    = bus.i_d_mask;
                last_d    = use_d;
                free_at   = cyc + L + 2;
            end
        end
    endtask

    task automatic check_cycle();
        bit cmd, ack;
        cmd = txn_valid && cyc >= t_start + 1 && cyc <= t_start + L;
        ack = txn_valid && cyc == t_start + L + 1;
        e_if_ack = ack && !t_d;
        e_d_ack  = ack && t_d;
        chk("mem_ren", 32'(bus.o_mem_ren), 32'(cmd && !t_write));
        chk("mem_wen", 32'(bus.o_mem_wen), 32'(cmd && t_write));
        chk("mem_addr", bus.o_mem_addr, cmd ? t_addr : 32'h0);
        if (!cmd || t_write) begin
            chk("mem_wdata", bus.o_mem_wdata, cmd ? t_wdata : 32'h0);
            chk("mem_mask", 32'(bus.o_mem_mask), cmd ? 32'(t_mask) : 32'h0);
        end
        chk("if_ack", 32'(bus.o_if_ack), 32'(e_if_ack));
        chk("d_ack", 32'(bus.o_d_ack), 32'(e_d_ack));
        chk("if_rdata", bus.o_if_rdata, e_if_ack ? t_rdata : 32'h0);
        chk("d_rdata", bus.o_d_rdata, (e_d_ack && !t_write) ? t_rdata : 32'h0);
        if (bus.o_if_ack === 1'b1) begin if_ack_n++; if_ack_cyc = cyc; end
        if (bus.o_d_ack === 1'b1) begin d_ack_n++; d_ack_cyc = cyc; end
    endtask

    // Requester behaviour for the cycle just entered.
    task automatic agents();
        int op;
        if (e_if_ack) begin
            if (if_reissue) bus.i_if_addr = {$urandom_range(0, 1023), 2'b00};
            else bus.i_if_req = 1'b0;
        end
        if (e_d_ack) begin
            if (d_reissue) bus.i_d_addr = {$urandom_range(0, 1023), 2'b00};
            else begin bus.i_d_ren = 1'b0; bus.i_d_wen = 1'b0; end
        end
        if (rand_mode) begin
            if (!bus.i_if_req && $urandom_range(0, 2) == 0) begin
                bus.i_if_req  = 1'b1;
                bus.i_if_addr = $urandom;
            end
            if (!(bus.i_d_ren || bus.i_d_wen) && $urandom_range(0, 2) == 0) begin
                op = int'($urandom_range(0, 2));
                bus.i_d_ren   = (op != 1);
                bus.i_d_wen   = (op != 0);
                bus.i_d_addr  = $urandom;
                bus.i_d_wdata = $urandom;
                bus.i_d_mask  = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic step();
        if (rand_rd) bus.i_mem_rdata = $urandom;
        model_sample();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        agents();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n, prev_if, prev_d;
        rst_n = 1'b0;
        in_reset = 1'b1; txn_valid = 1'b0; free_at = 0; last_d = 1'b0;
        if_reissue = 1'b0; d_reissue = 1'b0; rand_mode = 1'b0; rand_rd = 1'b0;
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0100;
        bus.i_d_ren = 1'b0; bus.i_d_wen = 1'b0; bus.i_d_addr = 32'h0;
        bus.i_d_wdata = 32'h0; bus.i_d_mask = 4'h0;
        bus.i_mem_rdata = 32'h0050_0093;

        // Reset held with a fetch request pending: everything stays 0.
        run(2);

        // Release: fetch of 0x100 acks L+1 cycles later.
        rst_n = 1'b1; in_reset = 1'b0; free_at = cyc;
        n = 0;
        while (bus.o_if_ack !== 1'b1 && n < 10) begin step(); n++; end
        chk("if_latency", 32'(n), 32'(L + 1));
        chk("if_first_rdata", bus.o_if_rdata, 32'h0050_0093);
        run(2);

        // Store.
        prev_if = if_ack_n; prev_d = d_ack_n;
        bus.i_d_wen = 1'b1; bus.i_d_addr = 32'h0000_2000;
        bus.i_d_wdata = 32'hDEAD_BEEF; bus.i_d_mask = 4'b1111;
        run(6);
        chk("store_d_acks", 32'(d_ack_n - prev_d), 32'd1);
        chk("store_no_if_ack", 32'(if_ack_n - prev_if), 32'd0);

        // Simultaneous fetch and load from IDLE.
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0104;
        bus.i_d_ren = 1'b1; bus.i_d_addr = 32'h0000_3000;
        bus.i_mem_rdata = 32'h1357_9BDF;
        run(12);
        chk("contention_spacing",
            32'(FAIR ? (d_ack_cyc - if_ack_cyc) : (if_ack_cyc - d_ack_cyc)), 32'(L + 2));

        // Both requesters re-request continuously.
        prev_if = if_ack_n; prev_d = d_ack_n;
        if_reissue = 1'b1; d_reissue = 1'b1;
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0200;
        bus.i_d_ren = 1'b1; bus.i_d_addr = 32'h0000_4000;
        run(16);
        chk("held_if_grants", 32'(if_ack_n - prev_if), FAIR ? 32'd2 : 32'd0);
        chk("held_d_grants", 32'(d_ack_n - prev_d), FAIR ? 32'd2 : 32'd4);
        if_reissue = 1'b0; d_reissue = 1'b0;
        run(12);

        // Asynchronous reset during the second command cycle.
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0300;
        run(2);
        #2 rst_n = 1'b0;
        #1;
        in_reset = 1'b1; txn_valid = 1'b0; last_d = 1'b0;
        chk("async_ren", 32'(bus.o_mem_ren), 32'd0);
        chk("async_addr", bus.o_mem_addr, 32'h0);
        chk("async_if_ack", 32'(bus.o_if_ack), 32'd0);
        prev_if = if_ack_n;
        run(2);
        rst_n = 1'b1; in_reset = 1'b0; free_at = cyc;
        run(6);
        chk("after_reset_if_acks", 32'(if_ack_n - prev_if), 32'd1);

        // ren and wen together: a store.
        prev_d = d_ack_n;
        bus.i_d_ren = 1'b1; bus.i_d_wen = 1'b1; bus.i_d_addr = 32'h0000_5000;
        bus.i_d_wdata = 32'h1234_5678; bus.i_d_mask = 4'b0101;
        run(6);
        chk("both_d_acks", 32'(d_ack_n - prev_d), 32'd1);

        // Randomized traffic with per-cycle memory data, then drain.
        rand_rd = 1'b1; rand_mode = 1'b1;
        run(400);
        rand_mode = 1'b0;
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
